// File: rtl/mem_access_pkg.sv
// Shared op codes, FSM encoding and op decode helpers for the MEM-stage access unit.
package mem_access_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_NONE = 4'd0;
    localparam logic [OP_W-1:0] OP_LB   = 4'd1;
    localparam logic [OP_W-1:0] OP_LBU  = 4'd2;
    localparam logic [OP_W-1:0] OP_LH   = 4'd3;
    localparam logic [OP_W-1:0] OP_LHU  = 4'd4;
    localparam logic [OP_W-1:0] OP_LW   = 4'd5;
    localparam logic [OP_W-1:0] OP_SB   = 4'd6;
    localparam logic [OP_W-1:0] OP_SH   = 4'd7;
    localparam logic [OP_W-1:0] OP_SW   = 4'd8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    // Codes 9..15 and OP_NONE decode as neither load nor store.
    function automatic logic op_is_load(input logic [OP_W-1:0] op);
        return (op != OP_NONE) && (op >= OP_LB) && (op <= OP_LW);
    endfunction

    function automatic logic op_is_store(input logic [OP_W-1:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    // Access size; non-memory ops report word size, which is harmless.
    function automatic size_e op_size(input logic [OP_W-1:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_B;
            OP_LH, OP_LHU, OP_SH: return SZ_H;
            default:              return SZ_W;
        endcase
    endfunction

    function automatic logic op_is_signed(input logic [OP_W-1:0] op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte/halfword lane extraction for loads and lane merge for sub-word stores.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0]     word_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [OP_W-1:0] op_i,
    input  logic [31:0]     wdata_i,
    output logic [31:0]     load_val_o,
    output logic [31:0]     merge_word_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    size_e       size;
    logic        sext;

    // Extract the addressed lane and extend it; build the merged store word.
    always_comb begin
        size         = op_size(op_i);
        sext         = op_is_signed(op_i);
        ld_byte      = word_i[{addr_lo_i, 3'b000} +: 8];
        ld_half      = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
        load_val_o   = word_i;
        merge_word_o = word_i;
        case (size)
            SZ_B: begin
                load_val_o = sext ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
                merge_word_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_H: begin
                load_val_o = sext ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
                if (addr_lo_i[1]) begin
                    merge_word_o[31:16] = wdata_i[15:0];
                end else begin
                    merge_word_o[15:0] = wdata_i[15:0];
                end
            end
            default: begin
                load_val_o   = word_i;
                merge_word_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: word memory access, sub-word load extension, RMW sub-word stores.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_wen,
    input  logic [DATA_W-1:0] mem_dout
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] rdata_q;
    logic              rdata_valid_q;
    logic              misalign_q;
    logic [DATA_W-1:0] merge_q;

    logic              ld_c, st_c, aligned_c, misalign_c, sub_st_c, word_st_c;
    size_e             size_c;
    logic [31:0]       load_val, merge_word;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
    assign mem_addr       = req_addr[ADDR_W+1:2];

    mem_lane_align u_lane (
        .word_i       (mem_dout),
        .addr_lo_i    (req_addr[1:0]),
        .op_i         (req_op),
        .wdata_i      (req_wdata),
        .load_val_o   (load_val),
        .merge_word_o (merge_word)
    );

    // Request decode and alignment check.
    always_comb begin
        ld_c   = op_is_load(req_op);
        st_c   = op_is_store(req_op);
        size_c = op_size(req_op);
        case (size_c)
            SZ_B:    aligned_c = 1'b1;
            SZ_H:    aligned_c = ~req_addr[0];
            default: aligned_c = (req_addr[1:0] == 2'b00);
        endcase
        misalign_c = (ld_c | st_c) & ~aligned_c;
        sub_st_c   = st_c & aligned_c & (size_c != SZ_W);
        word_st_c  = st_c & aligned_c & (size_c == SZ_W);
    end

    // Next state plus the combinational memory-side and stall outputs.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        mem_wen = 1'b0;
        mem_din = req_wdata;
        if (state_q == ST_RMW_WR) begin
            state_d = ST_IDLE;
            mem_din = merge_q;
            mem_wen = ~reset;
        end else begin
            stall   = sub_st_c & ~reset;
            mem_wen = word_st_c & ~reset;
            if (sub_st_c) begin
                state_d = ST_RMW_WR;
            end
        end
    end

    // State, load result, misalign pulse and merge word registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            merge_q       <= '0;
        end else begin
            state_q       <= state_d;
            rdata_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            if (state_q == ST_IDLE) begin
                misalign_q <= misalign_c;
                if (ld_c && aligned_c) begin
                    rdata_q       <= load_val;
                    rdata_valid_q <= 1'b1;
                end
                if (sub_st_c) begin
                    merge_q <= merge_word;
                end
            end
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign misalign    = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word memory model plus a byte-addressed reference model.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        misalign;
    logic [8:0]  mem_addr;
    logic [31:0] mem_din;
    logic        mem_wen;
    logic [31:0] mem_dout;

    logic [31:0] mem [0:511];
    logic        clr, pre_en;
    logic [8:0]  pre_addr;
    logic [31:0] pre_data;

    logic [7:0]  ref_mem [0:2047];
    logic [31:0] exp_rdata;
    int          n_vec;
    int          n_err;

    mem_access_unit #(.ADDR_W(9), .DATA_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .misalign    (misalign),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_wen     (mem_wen),
        .mem_dout    (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: synchronous write, asynchronous read.
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
        end else if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (mem_wen) begin
            mem[mem_addr] <= mem_din;
        end
    end
    assign mem_dout = mem[mem_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int op_bytes(input logic [3:0] op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] base;
        base = (a / 4) * 4;
        return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] a);
        logic [31:0] v;
        int          n;
        n = op_bytes(op);
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a + 32'(i)]) << (8 * i));
        if (op == OP_LB && v >= 32'h80)   v = v + 32'hFFFFFF00;
        if (op == OP_LH && v >= 32'h8000) v = v + 32'hFFFF0000;
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] wd);
        for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = 8'((wd >> (8 * i)) & 32'hFF);
    endtask

    // One pipeline request, checked cycle by cycle against the reference model.
    task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
        logic        ld, st, mis, sub, wst;
        int          sz;
        logic [31:0] a;
        ld  = (op >= 4'd1) && (op <= 4'd5);
        st  = (op >= 4'd6) && (op <= 4'd8);
        sz  = op_bytes(op);
        a   = addr % 2048;
        mis = (ld || st) && ((a % sz) != 0);
        sub = st && !mis && (sz < 4);
        wst = st && !mis && (sz == 4);
        @(negedge clk);
        req_op = op; req_addr = addr; req_wdata = wd;
        #1;
        check("stall", 32'(stall), 32'(sub));
        check("mem_wen", 32'(mem_wen), 32'(wst));
        check("mem_addr", 32'(mem_addr), a / 4);
        check("mem_din", mem_din, wd);
        if (st && !mis) ref_store(a, sz, wd);
        if (ld && !mis) exp_rdata = ref_load(op, a);
        @(posedge clk); #1;
        check("rdata_valid", 32'(rdata_valid), 32'(ld && !mis));
        check("rdata", rdata, exp_rdata);
        check("misalign", 32'(misalign), 32'(mis));
        if (sub) begin
            check("rmw_stall", 32'(stall), 32'h0);
            check("rmw_wen", 32'(mem_wen), 32'h1);
            check("rmw_din", mem_din, ref_word(a));
            @(posedge clk); #1;
            check("rmw_valid", 32'(rdata_valid), 32'h0);
            check("rmw_misalign", 32'(misalign), 32'h0);
        end
        check("mem_word", mem[a / 4], ref_word(a));
        req_op = OP_NONE;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        exp_rdata = 32'h0;
        reset = 1'b1; clr = 1'b1; pre_en = 1'b0; pre_addr = 9'd0; pre_data = 32'h0;
        req_op = OP_NONE; req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h0;
        ref_mem[12] = 8'hBB; ref_mem[13] = 8'hAA; ref_mem[14] = 8'h99; ref_mem[15] = 8'h88;

        // Reset, clear memory, preload word 3.
        @(posedge clk); #1;
        clr = 1'b0; pre_en = 1'b1; pre_addr = 9'd3; pre_data = 32'h8899AABB;
        @(posedge clk); #1;
        pre_en = 1'b0;
        check("rst_rdata", rdata, 32'h0);
        check("rst_valid", 32'(rdata_valid), 32'h0);
        check("rst_misalign", 32'(misalign), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_wen", 32'(mem_wen), 32'h0);
        @(negedge clk); reset = 1'b0;

        // Loads of every size and extension.
        do_op(OP_LB, 32'h0E, 32'h0);       check("tp_lb", rdata, 32'hFFFFFF99);
        do_op(OP_LBU, 32'h0E, 32'h0);      check("tp_lbu", rdata, 32'h00000099);
        do_op(OP_LH, 32'h0E, 32'h0);       check("tp_lh", rdata, 32'hFFFF8899);
        do_op(OP_LHU, 32'h0C, 32'h0);      check("tp_lhu", rdata, 32'h0000AABB);
        do_op(OP_LW, 32'h0C, 32'h0);       check("tp_lw", rdata, 32'h8899AABB);

        // Sub-word and word stores followed by readback.
        do_op(OP_SB, 32'h0D, 32'h55);
        do_op(OP_LW, 32'h0C, 32'h0);       check("tp_sb", rdata, 32'h889955BB);
        do_op(OP_SH, 32'h0E, 32'h1234);
        do_op(OP_LW, 32'h0C, 32'h0);       check("tp_sh", rdata, 32'h123455BB);
        do_op(OP_SW, 32'h0C, 32'hDEADBEEF);
        do_op(OP_LW, 32'h0C, 32'h0);       check("tp_sw", rdata, 32'hDEADBEEF);

        // Misaligned requests leave memory and rdata untouched.
        do_op(OP_LW, 32'h0D, 32'h0);
        do_op(OP_SH, 32'h0F, 32'hAAAA);
        do_op(OP_SW, 32'h0E, 32'h11111111);
        check("tp_mis_word", mem[3], 32'hDEADBEEF);
        check("tp_mis_rdata", rdata, 32'hDEADBEEF);

        // Reset asserted during the RMW write cycle discards the store.
        @(negedge clk);
        req_op = OP_SB; req_addr = 32'h0D; req_wdata = 32'h77;
        #1 check("rr_stall", 32'(stall), 32'h1);
        @(posedge clk); #1;
        check("rr_wen_pre", 32'(mem_wen), 32'h1);
        reset = 1'b1;
        #1;
        check("rr_wen", 32'(mem_wen), 32'h0);
        check("rr_stall0", 32'(stall), 32'h0);
        @(posedge clk); #1;
        req_op = OP_NONE;
        check("rr_word", mem[3], 32'hDEADBEEF);
        check("rr_rdata", rdata, 32'h0);
        check("rr_valid", 32'(rdata_valid), 32'h0);
        check("rr_misalign", 32'(misalign), 32'h0);
        @(negedge clk); reset = 1'b0; exp_rdata = 32'h0;
        #1;
        check("rr_idle_wen", 32'(mem_wen), 32'h0);
        check("rr_idle_stall", 32'(stall), 32'h0);

        // Address aliasing modulo 2 KiB.
        do_op(OP_LW, 32'h80C, 32'h0);      check("tp_alias", rdata, 32'hDEADBEEF);

        // Random traffic over a few words with random upper address bits.
        for (int k = 0; k < 300; k++) begin
            logic [3:0]  op;
            logic [31:0] addr;
            op   = 4'($urandom_range(0, 15));
            addr = ($urandom() & 32'hFFFFF800) | 32'($urandom_range(0, 31));
            do_op(op, addr, $urandom());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
